dplca_node_id_alloc: RTL

Consumer side of the DPLCA TXOP claim table. The aging state machine writes `txop_claim_table` and signals `dplca_txop_table_upd` and `dplca_new_age`. This block reads that table to pick an unclaimed PLCA local node ID. It holds the ID through one full aging window to detect conflicts, then publishes it to the PLCA control state machine. It sits between the aging block and PLCA control, inside the `plca` hierarchy.

---
 rtl/dplca_node_id_alloc_if.sv | 25 ++
 rtl/dplca_node_id_alloc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dplca_node_id_alloc_if.sv
// Aging-block view of the DPLCA TXOP claim table: edge-signalled updates,
// the per-TXOP claim report and the full claim bitmap.
interface dplca_node_id_alloc_if;
    logic         dplca_txop_table_upd;
    logic         dplca_new_age;
    logic [7:0]   dplca_txop_id;
    logic [1:0]   dplca_txop_claim;
    logic [255:0] txop_claim_table;

    modport master (
        output dplca_txop_table_upd,
        output dplca_new_age,
        output dplca_txop_id,
        output dplca_txop_claim,
        output txop_claim_table
    );

    modport slave (
        input dplca_txop_table_upd,
        input dplca_new_age,
        input dplca_txop_id,
        input dplca_txop_claim,
        input txop_claim_table
    );
endinterface

// File: rtl/dplca_node_id_alloc.sv
// Picks an unclaimed PLCA local node ID from the aging block's claim table,
// holds it conflict-free through CONFIRM_AGES aging windows, then publishes it.
module dplca_node_id_alloc #(
    parameter int CONFIRM_AGES = 1,
    parameter int RETRY_MAX    = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   dplca_en,
    dplca_node_id_alloc_if.slave   aging,
    input  logic [7:0]             max_node_id,
    output logic [7:0]             local_nodeID,
    output logic                   dplca_id_valid,
    output logic [3:0]             retry_cnt,
    output logic [2:0]             alloc_state
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_WAIT_AGE = 3'd1,
        ST_SCAN     = 3'd2,
        ST_CLAIM    = 3'd3,
        ST_ASSIGNED = 3'd4,
        ST_NO_FREE  = 3'd5
    } state_t;

    localparam logic [7:0] CONFIRM = 8'(CONFIRM_AGES);
    localparam logic [3:0] RETRY_SAT = 4'(RETRY_MAX);
    localparam logic [1:0] CLAIMED = 2'd1;

    state_t         state_reg, state_next;
    logic [7:0]     ptr_reg, ptr_next;
    logic [7:0]     age_cnt_reg, age_cnt_next;
    logic [7:0]     scan_cnt_reg, scan_cnt_next;
    logic [255:0]   snap_reg, snap_next;
    logic [7:0]     id_reg, id_next;
    logic           valid_reg, valid_next;
    logic [3:0]     retry_reg, retry_next;
    logic           upd_d_reg, age_d_reg;
    logic           upd_re_reg, upd_re_next;
    logic           age_re_reg, age_re_next;
    logic [7:0]     upd_id_reg, upd_id_next;
    logic [1:0]     upd_claim_reg, upd_claim_next;

    logic [7:0]     last_id;
    logic [7:0]     ptr_adv;
    logic [7:0]     id_adv;
    logic           upd_rise;
    logic           conflict;

    assign last_id  = max_node_id - 8'd1;
    assign ptr_adv  = (ptr_reg >= last_id) ? 8'd1 : ptr_reg + 8'd1;
    assign id_adv   = (id_reg  >= last_id) ? 8'd1 : id_reg  + 8'd1;
    assign upd_rise = aging.dplca_txop_table_upd & ~upd_d_reg;
    // The report is latched at its own edge so a late-changing id cannot alias.
    assign conflict = upd_re_reg && (upd_id_reg == id_reg) && (upd_claim_reg == CLAIMED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_DISABLED;
            ptr_reg       <= 8'd1;
            age_cnt_reg   <= 8'd0;
            scan_cnt_reg  <= 8'd0;
            snap_reg      <= '0;
            id_reg        <= 8'd0;
            valid_reg     <= 1'b0;
            retry_reg     <= 4'd0;
            upd_d_reg     <= 1'b0;
            age_d_reg     <= 1'b0;
            upd_re_reg    <= 1'b0;
            age_re_reg    <= 1'b0;
            upd_id_reg    <= 8'd0;
            upd_claim_reg <= 2'd0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            age_cnt_reg   <= age_cnt_next;
            scan_cnt_reg  <= scan_cnt_next;
            snap_reg      <= snap_next;
            id_reg        <= id_next;
            valid_reg     <= valid_next;
            retry_reg     <= retry_next;
            upd_d_reg     <= aging.dplca_txop_table_upd;
            age_d_reg     <= aging.dplca_new_age;
            upd_re_reg    <= upd_re_next;
            age_re_reg    <= age_re_next;
            upd_id_reg    <= upd_id_next;
            upd_claim_reg <= upd_claim_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        age_cnt_next   = age_cnt_reg;
        scan_cnt_next  = scan_cnt_reg;
        snap_next      = snap_reg;
        id_next        = id_reg;
        valid_next     = valid_reg;
        retry_next     = retry_reg;
        upd_re_next    = upd_rise & dplca_en & (state_reg != ST_DISABLED);
        age_re_next    = aging.dplca_new_age & ~age_d_reg & dplca_en & (state_reg != ST_DISABLED);
        upd_id_next    = upd_rise ? aging.dplca_txop_id    : upd_id_reg;
        upd_claim_next = upd_rise ? aging.dplca_txop_claim : upd_claim_reg;

        unique case (state_reg)
            ST_DISABLED: begin
                ptr_next     = 8'd1;
                age_cnt_next = 8'd0;
                id_next      = 8'd0;
                valid_next   = 1'b0;
                retry_next   = 4'd0;
                if (dplca_en) begin
                    state_next = ST_WAIT_AGE;
                end
            end
            ST_WAIT_AGE: begin
                if (age_re_reg) begin
                    snap_next     = aging.txop_claim_table;
                    scan_cnt_next = 8'd0;
                    state_next    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (max_node_id < 8'd2) begin
                    state_next = ST_NO_FREE;
                end else if (!snap_reg[ptr_reg]) begin
                    id_next      = ptr_reg;
                    age_cnt_next = 8'd0;
                    state_next   = ST_CLAIM;
                end else begin
                    ptr_next      = ptr_adv;
                    scan_cnt_next = scan_cnt_reg + 8'd1;
                    if (scan_cnt_reg + 8'd1 == last_id) begin
                        state_next = ST_NO_FREE;
                    end
                end
            end
            ST_CLAIM: begin
                if (conflict) begin
                    if (retry_reg != RETRY_SAT) begin
                        retry_next = retry_reg + 4'd1;
                    end
                    ptr_next   = id_adv;
                    state_next = ST_WAIT_AGE;
                end else if (age_re_reg) begin
                    age_cnt_next = age_cnt_reg + 8'd1;
                    if (age_cnt_reg + 8'd1 >= CONFIRM) begin
                        valid_next = 1'b1;
                        state_next = ST_ASSIGNED;
                    end
                end
            end
            ST_ASSIGNED: begin
                // Own transmissions claim the ID, so table reports are ignored here.
            end
            ST_NO_FREE: begin
                if (age_re_reg) begin
                    snap_next     = aging.txop_claim_table;
                    ptr_next      = 8'd1;
                    scan_cnt_next = 8'd0;
                    state_next    = ST_SCAN;
                end
            end
            default: begin
                state_next = ST_DISABLED;
            end
        endcase

        // Disable aborts any state and clears outputs on the very next edge.
        if (!dplca_en) begin
            state_next    = ST_DISABLED;
            ptr_next      = 8'd1;
            age_cnt_next  = 8'd0;
            scan_cnt_next = 8'd0;
            id_next       = 8'd0;
            valid_next    = 1'b0;
            retry_next    = 4'd0;
        end
    end

    assign local_nodeID   = id_reg;
    assign dplca_id_valid = valid_reg;
    assign retry_cnt      = retry_reg;
    assign alloc_state    = state_reg;

endmodule
